// File: rtl/controle_exibicao_sequencia_pkg.sv
// Shared constants for the memory game.
// Holds the state codes shown on the debug display, the default LED on/off
// durations and the sequence memory address width. The game control unit
// imports the same package so both blocks agree on these values.
package controle_exibicao_sequencia_pkg;

   localparam int LARGURA_ENDERECO = 4;

   // Default durations at a 1 kHz game clock: 1 s lit, 0.5 s dark.
   localparam int T_ACESO_PADRAO   = 1000;
   localparam int T_APAGADO_PADRAO = 500;

   // Codes presented on the hex debug display.
   localparam logic [3:0] COD_OCIOSO  = 4'd0;
   localparam logic [3:0] COD_ACESO   = 4'd1;
   localparam logic [3:0] COD_APAGADO = 4'd2;
   localparam logic [3:0] COD_FIM     = 4'd3;

   typedef enum logic [1:0] {
      OCIOSO  = 2'd0,
      ACESO   = 2'd1,
      APAGADO = 2'd2,
      FIM     = 2'd3
   } estado_t;

   // Timer width able to hold max(a,b)-1; never narrower than one bit.
   function automatic int largura_timer(input int a, input int b);
      int maior;
      int w;
      maior = (a > b) ? a : b;
      w     = $clog2(maior);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/controle_exibicao_sequencia_contador.sv
// contador_tempo_exibicao: phase duration counter.
// Counts up while conta=1, clears on zera (zera has priority) and raises fim
// while the count equals TERMINAL.
// Ports:
//   clock  - system clock, rising edge
//   reset  - asynchronous active-high reset
//   zera   - synchronous clear
//   conta  - count enable
//   fim    - high while count == TERMINAL
module contador_tempo_exibicao #(
   parameter int LARGURA  = 1,
   parameter int TERMINAL = 0
) (
   input  logic clock,
   input  logic reset,
   input  logic zera,
   input  logic conta,
   output logic fim
);

   localparam logic [LARGURA-1:0] UM       = LARGURA'(1);
   localparam logic [LARGURA-1:0] TERM_VAL = LARGURA'(TERMINAL);

   logic [LARGURA-1:0] valor_reg;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         valor_reg <= '0;
      end else if (zera) begin
         valor_reg <= '0;
      end else if (conta) begin
         valor_reg <= valor_reg + UM;
      end
   end

   assign fim = (valor_reg == TERM_VAL);

endmodule

// File: rtl/controle_exibicao_sequencia.sv
// controle_exibicao_sequencia: plays the stored sequence back before each round.
// Walks addresses 0..rodada, keeping each entry lit for T_ACESO cycles and
// dark for T_APAGADO cycles, then pulses pronto for one cycle.
// Ports:
//   clock     - system clock, rising edge
//   reset     - asynchronous active-high reset
//   iniciar   - start playback (only looked at while idle)
//   cancelar  - abort playback, back to idle on the next edge
//   rodada    - index of the last entry to show
//   endereco  - memory address of the entry being shown
//   sinal_led - datapath drives the LEDs from memory when 1
//   ocupado   - 1 whenever not idle
//   pronto    - one-cycle pulse on normal completion
//   db_estado - state code for the debug display
module controle_exibicao_sequencia
   import controle_exibicao_sequencia_pkg::*;
#(
   parameter int T_ACESO   = T_ACESO_PADRAO,
   parameter int T_APAGADO = T_APAGADO_PADRAO
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic                        iniciar,
   input  logic                        cancelar,
   input  logic [LARGURA_ENDERECO-1:0] rodada,
   output logic [LARGURA_ENDERECO-1:0] endereco,
   output logic                        sinal_led,
   output logic                        ocupado,
   output logic                        pronto,
   output logic [3:0]                  db_estado
);

   localparam int LARGURA_TIMER = largura_timer(T_ACESO, T_APAGADO);

   estado_t                     estado_reg, estado_next;
   logic [LARGURA_ENDERECO-1:0] endereco_reg, endereco_next;
   logic [LARGURA_ENDERECO-1:0] rodada_reg, rodada_next;

   logic fim_aceso, fim_apagado;
   logic zera_aceso, zera_apagado;

   // One counter per phase. Each is held at zero outside its own phase, so
   // every phase starts counting from zero without an explicit reload.
   assign zera_aceso   = (estado_reg != ACESO)   || fim_aceso   || cancelar;
   assign zera_apagado = (estado_reg != APAGADO) || fim_apagado || cancelar;

   contador_tempo_exibicao #(
      .LARGURA  (LARGURA_TIMER),
      .TERMINAL (T_ACESO - 1)
   ) u_tempo_aceso (
      .clock (clock),
      .reset (reset),
      .zera  (zera_aceso),
      .conta (estado_reg == ACESO),
      .fim   (fim_aceso)
   );

   contador_tempo_exibicao #(
      .LARGURA  (LARGURA_TIMER),
      .TERMINAL (T_APAGADO - 1)
   ) u_tempo_apagado (
      .clock (clock),
      .reset (reset),
      .zera  (zera_apagado),
      .conta (estado_reg == APAGADO),
      .fim   (fim_apagado)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         estado_reg   <= OCIOSO;
         endereco_reg <= '0;
         rodada_reg   <= '0;
      end else begin
         estado_reg   <= estado_next;
         endereco_reg <= endereco_next;
         rodada_reg   <= rodada_next;
      end
   end

   always_comb begin
      estado_next   = estado_reg;
      endereco_next = endereco_reg;
      rodada_next   = rodada_reg;

      case (estado_reg)
         OCIOSO: begin
            // cancelar wins over a simultaneous iniciar
            if (iniciar && !cancelar) begin
               rodada_next = rodada;
               estado_next = ACESO;
            end
         end
         ACESO: begin
            if (fim_aceso) estado_next = APAGADO;
         end
         APAGADO: begin
            if (fim_apagado) begin
               if (endereco_reg == rodada_reg) begin
                  estado_next = FIM;
               end else begin
                  endereco_next = endereco_reg + 4'd1;
                  estado_next   = ACESO;
               end
            end
         end
         FIM: begin
            estado_next = OCIOSO;
         end
         default: begin
            estado_next = OCIOSO;
         end
      endcase

      if (cancelar && (estado_reg != OCIOSO)) estado_next = OCIOSO;

      // Address always reads 0 while idle, whatever path led there.
      if (estado_next == OCIOSO) endereco_next = '0;
   end

   // Moore outputs: decoded from registered state only.
   always_comb begin
      case (estado_reg)
         ACESO:   db_estado = COD_ACESO;
         APAGADO: db_estado = COD_APAGADO;
         FIM:     db_estado = COD_FIM;
         default: db_estado = COD_OCIOSO;
      endcase
   end

   assign endereco  = endereco_reg;
   assign sinal_led = (estado_reg == ACESO);
   assign ocupado   = (estado_reg != OCIOSO);
   assign pronto    = (estado_reg == FIM);

endmodule
